decrementer_timer_8_bit: RTL
============================

# decrementer_timer_8_bit

Registered 8-bit down-counting timer: the decrement-side counterpart of the team's registered incrementer. A value is loaded and started, then decremented once per enabled cycle through a ripple half-subtractor chain, and a one-cycle done pulse is produced on reaching zero. It sits beside the incrementer in the arithmetic/timing library and serves as a programmable delay or terminal-count source.

## Interface
- WIDTH, 8, counter width in bits; the borrow chain is generated per bit.
- i_clk  in  1  clock; all state updates on rising edge.
- i_RESET  in  1  reset, synchronous, active-high.
- i_load  in  1  capture i_loadValue into count and reload registers.
- i_loadValue  in  WIDTH  value to load.
- i_start  in  1  begin countdown; honoured only in S_IDLE.
- i_en  in  1  decrement enable in S_RUN; low = pause, count holds.
- i_abort  in  1  leave S_RUN or S_DONE to S_IDLE; count holds.
- o_count  out  WIDTH  current count (registered).
- o_busy  out  1  high while in S_RUN.
- o_done  out  1  high for exactly one cycle in S_DONE.

## Operation
- Reset: state S_IDLE, o_count=0, reload register=0, o_busy=0, o_done=0. Reset wins over all inputs, including mid-countdown.
- Decrement: o_count minus 1 through the half-subtractor chain, bit 0 subtrahend tied to 1. Borrow out is unused: the FSM never decrements at 0.
- S_IDLE:
  - i_load captures i_loadValue into o_count and the reload register.
  - i_start: go to S_RUN if the effective count is nonzero, else to S_DONE. The effective count is i_loadValue when i_load is high in the same cycle, else o_count.
- S_RUN, priority order:
  - i_abort: go to S_IDLE.
  - i_load: reload o_count. Stay in S_RUN, or go to S_DONE if the loaded value is 0.
  - i_en with o_count==1: o_count becomes 0, go to S_DONE.
  - i_en otherwise: decrement.
  - i_en low: hold.
- S_DONE: lasts one cycle, then S_IDLE. i_load in S_DONE is captured. i_start in S_DONE is ignored.

## Timing
- o_busy and o_done are Moore outputs decoded from the state register. No combinational input-to-output path.
- Loading N, then i_start at edge 0 with i_en held high:
  - o_count=N-k after edge k.
  - o_count=0 and o_done=1 after edge N; o_busy low from that same edge.
  - S_IDLE after edge N+1.
- Each cycle of i_en low adds one cycle to this schedule.
- Start with a zero count: o_done=1 after edge 0, o_busy never rises.
- o_count wraps only through i_load; it never decrements below 0.

## Configuration
- DECREMENTER_TIMER_AUTO_RELOAD_EN defined:
  - S_DONE goes to S_RUN with o_count = reload register when that register is nonzero, giving a periodic o_done every N+1 cycles with i_en high.
  - A zero reload register, or i_abort in S_DONE, goes to S_IDLE.
  - An i_load in S_DONE updates both registers and the new value is used.
- Undefined: S_DONE always goes to S_IDLE. The reload register is still written but not read by the FSM.

## Structure
- Package decrementer_timer_pkg:
  - typedef enum t_state {S_IDLE, S_RUN, S_DONE}.
  - localparam DEFAULT_WIDTH=8.
- Sub-module Half_Subtractor (a, b -> diff, borrow), instantiated WIDTH times in a generate loop as the ripple borrow chain.

## Test plan
- Load 5, start, i_en high -> o_count 5,4,3,2,1,0; o_done=1 for one cycle 5 edges after start; o_busy high for 5 cycles.
- Load 3, start, i_en low for 2 cycles mid-count -> o_done delayed by exactly 2 cycles; o_count holds during the pause.
- Load 0x00 then start -> o_done next cycle, o_busy stays 0. Load 0xFF then start -> 255 decrements, then done.
- Reset asserted while o_count=0x40 in S_RUN -> next edge o_count=0, o_busy=0, o_done=0. i_abort at count 2 -> S_IDLE with o_count=2.
- i_load 9 during S_RUN at count 4 -> countdown continues from 9. Simultaneous i_load 7 and i_start in S_IDLE -> runs from 7.
- With DECREMENTER_TIMER_AUTO_RELOAD_EN, load 2 and start -> o_done every 3 cycles until i_abort; i_abort in S_DONE -> S_IDLE.

Source files
------------

// File: rtl/decrementer_timer_8_bit_pkg.sv
// Shared types and constants for the 8-bit down-counting timer.
package decrementer_timer_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } t_state;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/decrementer_timer_8_bit_if.sv
// Control/status bundle between the timer and its user.
interface decrementer_timer_8_bit_if
  import decrementer_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             i_load;
  logic [WIDTH-1:0] i_loadValue;
  logic             i_start;
  logic             i_en;
  logic             i_abort;
  logic [WIDTH-1:0] o_count;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_load, i_loadValue, i_start, i_en, i_abort,
    input  o_count, o_busy, o_done
  );

  modport slave (
    input  i_load, i_loadValue, i_start, i_en, i_abort,
    output o_count, o_busy, o_done
  );
endinterface

// File: rtl/decrementer_timer_8_bit_half_subtractor.sv
// One-bit half subtractor: a - b, borrow out when b exceeds a.
module Half_Subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);
  assign diff   = a ^ b;
  assign borrow = ~a & b;
endmodule

// File: rtl/decrementer_timer_8_bit.sv
// Registered down-counting timer with one-cycle done pulse.
// Optional periodic restart from the reload register: DECREMENTER_TIMER_AUTO_RELOAD_EN.
module decrementer_timer_8_bit
  import decrementer_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                      i_clk,
  input logic                      i_RESET,
  decrementer_timer_8_bit_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  t_state           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             busy_q, done_q;

  // count - 1: bit 0 subtracts a constant 1, higher bits subtract the incoming borrow
  logic [WIDTH-1:0] dec, borrow, sub_in;
  logic             unused_borrow;

  assign sub_in        = {borrow[WIDTH-2:0], 1'b1};
  assign unused_borrow = borrow[WIDTH-1];

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_borrow_chain
    Half_Subtractor u_hs (
      .a      (count_q[gi]),
      .b      (sub_in[gi]),
      .diff   (dec[gi]),
      .borrow (borrow[gi])
    );
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.i_load) begin
          count_d  = bus.i_loadValue;
          reload_d = bus.i_loadValue;
        end
        if (bus.i_start) state_d = (count_d != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else if (bus.i_load) begin
          count_d  = bus.i_loadValue;
          reload_d = bus.i_loadValue;
          if (bus.i_loadValue == '0) state_d = S_DONE;
        end else if (bus.i_en) begin
          count_d = dec;
          if (count_q == ONE) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.i_load) begin
          count_d  = bus.i_loadValue;
          reload_d = bus.i_loadValue;
        end
`ifdef DECREMENTER_TIMER_AUTO_RELOAD_EN
        if (bus.i_abort || reload_d == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
          count_d = reload_d;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifndef DECREMENTER_TIMER_AUTO_RELOAD_EN
  logic unused_reload;
  assign unused_reload = ^reload_q;
`endif

  // Registered state, count and Moore outputs
  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      busy_q   <= (state_d == S_RUN);
      done_q   <= (state_d == S_DONE);
    end
  end

  assign bus.o_count = count_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule
